// File: rtl/object_reporter_pkg.sv
// object_reporter_pkg
//   Shared definitions for the object reporter: default label and
//   coordinate widths and the scan state encoding.
package object_reporter_pkg;

    localparam int WORD_SIZE_DEF = 8;
    localparam int LOC_SIZE_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DIV   = 3'd3,
        ST_EMIT  = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

endpackage

// File: rtl/object_reporter_serial_divider.sv
// object_reporter_serial_divider
//   Restoring unsigned divider producing one quotient bit per cycle.
//   The first bit is resolved on the start edge, so the quotient is
//   complete WIDTH cycles after start and done pulses for one cycle.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : load dividend/divisor and begin (one-cycle pulse)
//   dividend     : WIDTH-bit numerator
//   divisor      : WIDTH-bit denominator (nonzero)
//   quotient     : floor(dividend / divisor), valid while done is high
//   done         : one-cycle pulse when quotient is complete
module object_reporter_serial_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic [CW-1:0]    cnt_r;
    logic             run_r;
    logic             done_r;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The carry-out bit
    // (old remainder MSB) means the shifted value exceeds any divisor;
    // the WIDTH-bit wrapped difference is still exact because the true
    // result is below the divisor.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH-1:0] trial;
        trial = {rem[WIDTH-2:0], quo[WIDTH-1]};
        if (rem[WIDTH-1] || (trial >= dvs)) begin
            div_step = {trial - dvs, quo[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {trial, quo[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Iteration state: first step on start, WIDTH-1 further steps while running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_r  <= {WIDTH{1'b0}};
            quo_r  <= {WIDTH{1'b0}};
            div_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            run_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            {rem_r, quo_r} <= div_step({WIDTH{1'b0}}, dividend, divisor);
            div_r  <= divisor;
            cnt_r  <= CW'(1);
            run_r  <= 1'b1;
            done_r <= 1'b0;
        end else if (run_r) begin
            {rem_r, quo_r} <= div_step(rem_r, quo_r, div_r);
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CW'(WIDTH - 1)) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign quotient = quo_r;
    assign done     = done_r;

endmodule

// File: rtl/object_reporter.sv
// object_reporter
//   Walks the labeler's object table for labels 1..num_labels-1, drops
//   objects below MIN_AREA (and all zero-area ones), computes the integer
//   centroid with two serial dividers and emits one record per accepted
//   object on a valid/ready stream.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, num_labels     : scan request and label count (sampled in IDLE)
//   obj_id                : table read address
//   obj_area, obj_x, obj_y: table data, one cycle after obj_id
//   out_valid, out_ready  : record handshake
//   out_label, out_area,
//   out_cx, out_cy        : record fields
//   busy, done, obj_count : status
module object_reporter
    import object_reporter_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int LOC_SIZE  = LOC_SIZE_DEF,
    parameter int MIN_AREA  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] num_labels,
    output logic [WORD_SIZE-1:0] obj_id,
    input  logic [LOC_SIZE-1:0]  obj_area,
    input  logic [LOC_SIZE-1:0]  obj_x,
    input  logic [LOC_SIZE-1:0]  obj_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_label,
    output logic [LOC_SIZE-1:0]  out_area,
    output logic [LOC_SIZE-1:0]  out_cx,
    output logic [LOC_SIZE-1:0]  out_cy,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] obj_count
);

    state_e               state_r, next_state_s;
    logic [WORD_SIZE-1:0] last_r, id_r, id_next_s, obj_id_r, obj_count_r, out_label_r;
    logic [LOC_SIZE-1:0]  area_r, out_area_r, out_cx_r, out_cy_r;
    logic                 out_valid_r, busy_r, done_r;
    logic                 is_last_s, area_ok_s, div_start_s, take_s;
    logic [LOC_SIZE-1:0]  qx_s, qy_s;
    logic                 x_done_s, y_done_s;

    assign is_last_s = (id_r == (last_r - WORD_SIZE'(1)));
    assign area_ok_s = (obj_area != {LOC_SIZE{1'b0}}) && (obj_area >= LOC_SIZE'(MIN_AREA));

    object_reporter_serial_divider #(.WIDTH(LOC_SIZE)) u_div_x (
        .clk(clk), .reset_n(reset_n), .start(div_start_s),
        .dividend(obj_x), .divisor(obj_area), .quotient(qx_s), .done(x_done_s)
    );

    object_reporter_serial_divider #(.WIDTH(LOC_SIZE)) u_div_y (
        .clk(clk), .reset_n(reset_n), .start(div_start_s),
        .dividend(obj_y), .divisor(obj_area), .quotient(qy_s), .done(y_done_s)
    );

    // Next-state, next-id and handshake decode.
    always_comb begin
        next_state_s = state_r;
        id_next_s    = id_r;
        div_start_s  = 1'b0;
        take_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    id_next_s    = WORD_SIZE'(1);
                    next_state_s = (num_labels <= WORD_SIZE'(1)) ? ST_FIN : ST_READ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_READ: next_state_s = ST_CHECK;
            ST_CHECK: begin
                if (area_ok_s) begin
                    div_start_s  = 1'b1;
                    next_state_s = ST_DIV;
                end else if (is_last_s) begin
                    next_state_s = ST_FIN;
                end else begin
                    id_next_s    = id_r + WORD_SIZE'(1);
                    next_state_s = ST_READ;
                end
            end
            ST_DIV: begin
                if (x_done_s && y_done_s) begin
                    next_state_s = ST_EMIT;
                end else begin
                    next_state_s = ST_DIV;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    take_s = 1'b1;
                    if (is_last_s) begin
                        next_state_s = ST_FIN;
                    end else begin
                        id_next_s    = id_r + WORD_SIZE'(1);
                        next_state_s = ST_READ;
                    end
                end else begin
                    next_state_s = ST_EMIT;
                end
            end
            ST_FIN:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, scan counters and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            id_r        <= {WORD_SIZE{1'b0}};
            last_r      <= {WORD_SIZE{1'b0}};
            obj_id_r    <= {WORD_SIZE{1'b0}};
            obj_count_r <= {WORD_SIZE{1'b0}};
            area_r      <= {LOC_SIZE{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            id_r    <= id_next_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (state_r == ST_FIN);
            if (state_r == ST_IDLE && start) begin
                last_r      <= num_labels;
                obj_count_r <= {WORD_SIZE{1'b0}};
            end else if (take_s) begin
                obj_count_r <= obj_count_r + WORD_SIZE'(1);
            end
            // Address is presented for the whole READ cycle; data arrives in CHECK.
            if (next_state_s == ST_READ) begin
                obj_id_r <= id_next_s;
            end
            if (state_r == ST_CHECK) begin
                area_r <= obj_area;
            end
        end
    end

    // Output record: loaded once when the dividers finish, frozen through EMIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_label_r <= {WORD_SIZE{1'b0}};
            out_area_r  <= {LOC_SIZE{1'b0}};
            out_cx_r    <= {LOC_SIZE{1'b0}};
            out_cy_r    <= {LOC_SIZE{1'b0}};
        end else begin
            out_valid_r <= (next_state_s == ST_EMIT);
            if (state_r == ST_DIV && next_state_s == ST_EMIT) begin
                out_label_r <= id_r;
                out_area_r  <= area_r;
                out_cx_r    <= qx_s;
                out_cy_r    <= qy_s;
            end
        end
    end

    assign obj_id    = obj_id_r;
    assign out_valid = out_valid_r;
    assign out_label = out_label_r;
    assign out_area  = out_area_r;
    assign out_cx    = out_cx_r;
    assign out_cy    = out_cy_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign obj_count = obj_count_r;

endmodule

// File: tb/tb_object_reporter.sv
// tb_object_reporter
//   Randomized self-checking bench. A behavioural table model answers
//   obj_id reads; expected records are computed from the table with plain
//   integer division and compared against every accepted record.
module tb_object_reporter;

    localparam int WS   = 8;
    localparam int LS   = 16;
    localparam int MINA = 3;
    localparam int RW   = WS + 3 * LS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [WS-1:0] num_labels = '0;
    logic [WS-1:0] obj_id;
    logic [LS-1:0] obj_area, obj_x, obj_y;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WS-1:0] out_label;
    logic [LS-1:0] out_area, out_cx, out_cy;
    logic          busy, done;
    logic [WS-1:0] obj_count;

    object_reporter #(.WORD_SIZE(WS), .LOC_SIZE(LS), .MIN_AREA(MINA)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_labels(num_labels),
        .obj_id(obj_id), .obj_area(obj_area), .obj_x(obj_x), .obj_y(obj_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_label(out_label),
        .out_area(out_area), .out_cx(out_cx), .out_cy(out_cy),
        .busy(busy), .done(done), .obj_count(obj_count)
    );

    always #5 clk = ~clk;

    // Labeler data table with one cycle of read latency.
    logic [LS-1:0] t_area [256];
    logic [LS-1:0] t_x    [256];
    logic [LS-1:0] t_y    [256];

    always @(posedge clk) begin
        obj_area <= t_area[obj_id];
        obj_x    <= t_x[obj_id];
        obj_y    <= t_y[obj_id];
    end

    int checks = 0;
    int errors = 0;
    int mode = 1;          // 0: random ready, 1: ready high, 2: ready low
    int done_cnt = 0;
    logic [RW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < 256; i++) begin
            t_area[i] = '0;
            t_x[i]    = '0;
            t_y[i]    = '0;
        end
    endtask

    // Reference model: every label in 1..n-1 passing the area filter, in order.
    function automatic int build_exp(input int n);
        int cnt = 0;
        logic [WS-1:0] lab;
        logic [LS-1:0] qx, qy;
        exp_q.delete();
        for (int l = 1; l < n; l++) begin
            if (t_area[l] != 0 && t_area[l] >= MINA) begin
                lab = WS'(l);
                qx  = t_x[l] / t_area[l];
                qy  = t_y[l] / t_area[l];
                exp_q.push_back({lab, t_area[l], qx, qy});
                cnt++;
            end
        end
        return cnt;
    endfunction

    // Record monitor and ready driver.
    initial begin : monitor
        bit            prev_stall = 1'b0;
        logic [RW-1:0] prev_rec = '0;
        logic [RW-1:0] rec;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
                out_ready  = 1'b0;
                continue;
            end
            rec = {out_label, out_area, out_cx, out_cy};
            if (prev_stall) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_fields", rec, prev_rec);
            end
            if (done) done_cnt++;
            case (mode)
                0:       out_ready = ($urandom_range(0, 2) != 0);
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("rec_extra", exp_q.size(), 1);
                else                   check_eq("rec", rec, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_rec   = rec;
        end
    end

    // Full scan: returns done latency and first out_valid latency (negedges from start).
    task automatic run_scan(input int n, input string tag, input bit bp, input bit poke,
                            output int lat_done, output int lat_valid);
        int cnt, cyc, d0, stall;
        cnt = build_exp(n);
        d0 = done_cnt;
        stall = 0;
        lat_valid = -1;
        @(negedge clk);
        num_labels = WS'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (out_valid && lat_valid < 0) lat_valid = cyc + 1;
            if (bp && mode == 2 && out_valid) begin
                stall++;
                if (stall == 10) mode = 1;
            end
            if (poke && cyc == 5 && busy) begin
                start = 1'b1;
                num_labels = WS'($urandom);
            end
        end
        lat_done = cyc + 1;
        check_eq({tag, "_timeout"}, cyc < 5000, 1);
        check_eq({tag, "_count"}, obj_count, cnt);
        check_eq({tag, "_left"}, exp_q.size(), 0);
        @(negedge clk);
        check_eq({tag, "_done_pulses"}, done_cnt - d0, 1);
        check_eq({tag, "_done_low"}, done, 0);
    endtask

    initial begin : main
        int ld, lv, n;
        clear_table();
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {obj_id, out_valid, out_label, out_area, out_cx, out_cy, busy, done, obj_count}, 0);
        reset_n = 1'b1;

        // Empty frames
        mode = 1;
        run_scan(1, "empty1", 0, 0, ld, lv);
        check_eq("empty1_lat", ld, 2);
        check_eq("empty1_novalid", lv, -1);
        run_scan(0, "empty0", 0, 0, ld, lv);
        check_eq("empty0_lat", ld, 2);

        // Single object
        t_area[1] = 16'd4; t_x[1] = 16'd10; t_y[1] = 16'd22;
        run_scan(2, "single", 0, 0, ld, lv);
        check_eq("single_vlat", lv, 19);

        // Area filter
        t_area[1] = 16'd2;
        t_area[2] = 16'd5; t_x[2] = 16'd25; t_y[2] = 16'd50;
        run_scan(3, "filter", 0, 0, ld, lv);

        // Backpressure
        mode = 2;
        run_scan(3, "bp", 1, 0, ld, lv);
        mode = 1;

        // Reset during DIV
        t_area[1] = 16'd7; t_x[1] = 16'd1000; t_y[1] = 16'd999;
        n = build_exp(2);
        @(negedge clk);
        num_labels = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        ld = done_cnt;
        #2 reset_n = 1'b0;
        exp_q.delete();
        #1 check_eq("midrst_outs", {obj_id, out_valid, out_label, out_area, out_cx, out_cy, busy, done, obj_count}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        check_eq("midrst_nodone", done_cnt - ld, 0);
        check_eq("midrst_idle", busy, 0);
        run_scan(2, "rescan", 0, 0, ld, lv);

        // Saturated count, all areas zero, with an ignored start
        clear_table();
        run_scan(255, "sat", 0, 1, ld, lv);
        check_eq("sat_lastid", obj_id, 254);

        // Random frames with random backpressure and ignored starts
        mode = 0;
        for (int f = 0; f < 8; f++) begin
            clear_table();
            n = $urandom_range(0, 24);
            for (int l = 1; l < 256; l++) begin
                t_area[l] = ($urandom_range(0, 2) == 0) ? LS'($urandom_range(1, 65535))
                                                        : LS'($urandom_range(0, 6));
                t_x[l] = LS'($urandom);
                t_y[l] = LS'($urandom);
            end
            run_scan(n, "rand", 0, f[0], ld, lv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
